// File: rtl/env_pkg.sv
// Shared types and helpers for the ADSR envelope generator.
// Optional build: ADSR_EXP_RELEASE_EN selects an exponential release curve.
package env_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StAttack  = 3'd1,
        StDecay   = 3'd2,
        StSustain = 3'd3,
        StRelease = 3'd4
    } env_state_t;

    // Largest positive Q1.(width-1) value, i.e. unity gain.
    function automatic int unsigned env_max(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned sat_clamp(input int unsigned value,
                                              input int unsigned limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/env_sat_step.sv
// Saturating add/subtract of a step against a limit, evaluated one bit wider than the level.
// Shared by the attack, decay and release paths of adsr_envelope.
module env_sat_step #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic [DATA_WIDTH-1:0] step_i,
    input  logic [DATA_WIDTH-1:0] limit_i,
    input  logic                  sub_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  hit_o
);

    logic [DATA_WIDTH:0] sum;
    logic [DATA_WIDTH:0] diff;

    assign sum  = {1'b0, level_i} + {1'b0, step_i};
    assign diff = {1'b0, level_i} - {1'b0, step_i};

    always_comb begin
        result_o = limit_i;
        hit_o    = 1'b1;
        if (sub_i) begin
            // diff[MSB] set means the subtraction borrowed, i.e. went below zero
            if (!diff[DATA_WIDTH] && (diff > {1'b0, limit_i})) begin
                result_o = diff[DATA_WIDTH-1:0];
                hit_o    = 1'b0;
            end
        end else begin
            if (sum < {1'b0, limit_i}) begin
                result_o = sum[DATA_WIDTH-1:0];
                hit_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator producing a non-negative Q1.(DATA_WIDTH-1) gain.
// Define ADSR_EXP_RELEASE_EN for an exponential release (release_step_i[3:0] is a shift).
module adsr_envelope
    import env_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         valid_i,
    input  logic                         gate_i,
    input  logic        [DATA_WIDTH-1:0] attack_step_i,
    input  logic        [DATA_WIDTH-1:0] decay_step_i,
    input  logic        [DATA_WIDTH-1:0] sustain_i,
    input  logic        [DATA_WIDTH-1:0] release_step_i,
    output logic signed [DATA_WIDTH-1:0] env_o,
    output logic                         valid_o,
    output logic        [2:0]            state_o,
    output logic                         idle_o
);

    localparam logic [DATA_WIDTH-1:0] EnvMax = DATA_WIDTH'(env_max(DATA_WIDTH));

    env_state_t            state_q;
    logic [DATA_WIDTH-1:0] level_q;
    logic                  gate_q;
    logic                  valid_q;

    logic                  rise;
    logic                  fall;
    logic [DATA_WIDTH-1:0] sustain_lvl;
    logic [DATA_WIDTH-1:0] rel_dec;
    logic [DATA_WIDTH-1:0] step_val;
    logic [DATA_WIDTH-1:0] step_limit;
    logic                  step_sub;
    logic [DATA_WIDTH-1:0] step_res;
    logic                  step_hit;

    assign rise        = gate_i & ~gate_q;
    assign fall        = ~gate_i & gate_q;
    assign sustain_lvl = DATA_WIDTH'(sat_clamp(32'(sustain_i), 32'(EnvMax)));

`ifdef ADSR_EXP_RELEASE_EN
    logic [DATA_WIDTH-1:0] rel_shifted;
    logic                  unused_rel_hi;

    assign rel_shifted   = level_q >> release_step_i[3:0];
    assign rel_dec       = (rel_shifted == '0) ? DATA_WIDTH'(1) : rel_shifted;
    assign unused_rel_hi = ^release_step_i[DATA_WIDTH-1:4];
`else
    assign rel_dec = release_step_i;
`endif

    // A rise always takes the attack path, from whatever level the voice is at.
    always_comb begin
        step_val   = attack_step_i;
        step_limit = EnvMax;
        step_sub   = 1'b0;
        if (!rise) begin
            case (state_q)
                StDecay: begin
                    step_val   = decay_step_i;
                    step_limit = sustain_lvl;
                    step_sub   = 1'b1;
                end
                StRelease: begin
                    step_val   = rel_dec;
                    step_limit = '0;
                    step_sub   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    env_sat_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_sat_step (
        .level_i  (level_q),
        .step_i   (step_val),
        .limit_i  (step_limit),
        .sub_i    (step_sub),
        .result_o (step_res),
        .hit_o    (step_hit)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            level_q <= '0;
            gate_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (valid_i) begin
            gate_q  <= gate_i;
            valid_q <= 1'b1;
            if (rise) begin
                level_q <= step_res;
                state_q <= step_hit ? StDecay : StAttack;
            end else if (fall && (state_q != StIdle) && (state_q != StRelease)) begin
                // Fall wins over any saturation/threshold on this tick; level holds.
                state_q <= StRelease;
            end else begin
                case (state_q)
                    StIdle: begin
                        level_q <= '0;
                    end
                    StAttack: begin
                        level_q <= step_res;
                        if (step_hit) state_q <= StDecay;
                    end
                    StDecay: begin
                        level_q <= step_res;
                        if (step_hit) state_q <= StSustain;
                    end
                    StSustain: begin
                        level_q <= sustain_lvl;
                    end
                    StRelease: begin
                        level_q <= step_res;
                        if (step_hit) state_q <= StIdle;
                    end
                    default: begin
                        level_q <= '0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end else begin
            valid_q <= 1'b0;
        end
    end

    assign env_o   = $signed(level_q);
    assign valid_o = valid_q;
    assign state_o = state_q;
    assign idle_o  = (state_q == StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed and randomized checks of adsr_envelope against an integer ADSR reference model.
module tb_adsr_envelope;

    localparam int W     = 16;
    localparam int MAXV  = 32767;
    localparam int S_IDL = 0;
    localparam int S_ATK = 1;
    localparam int S_DEC = 2;
    localparam int S_SUS = 3;
    localparam int S_REL = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                valid_i;
    logic                gate_i;
    logic        [W-1:0] attack_step_i;
    logic        [W-1:0] decay_step_i;
    logic        [W-1:0] sustain_i;
    logic        [W-1:0] release_step_i;
    logic signed [W-1:0] env_o;
    logic                valid_o;
    logic        [2:0]   state_o;
    logic                idle_o;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int  m_lvl   = 0;
    int  m_st    = S_IDL;
    bit  m_gate  = 1'b0;
    bit  m_valid = 1'b0;

    adsr_envelope #(
        .DATA_WIDTH(W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .gate_i         (gate_i),
        .attack_step_i  (attack_step_i),
        .decay_step_i   (decay_step_i),
        .sustain_i      (sustain_i),
        .release_step_i (release_step_i),
        .env_o          (env_o),
        .valid_o        (valid_o),
        .state_o        (state_o),
        .idle_o         (idle_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl   = 0;
        m_st    = S_IDL;
        m_gate  = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic model_tick(input bit v, input bit g);
        bit rise, fall;
        int sus, d;
        if (!v) begin
            m_valid = 1'b0;
            return;
        end
        m_valid = 1'b1;
        rise    = g && !m_gate;
        fall    = !g && m_gate;
        m_gate  = g;
        sus     = (int'(sustain_i) > MAXV) ? MAXV : int'(sustain_i);
        if (rise) begin
            m_lvl = m_lvl + int'(attack_step_i);
            if (m_lvl >= MAXV) begin
                m_lvl = MAXV;
                m_st  = S_DEC;
            end else begin
                m_st = S_ATK;
            end
        end else if (fall && (m_st == S_ATK || m_st == S_DEC || m_st == S_SUS)) begin
            m_st = S_REL;
        end else begin
            case (m_st)
                S_IDL: m_lvl = 0;
                S_ATK: begin
                    m_lvl = m_lvl + int'(attack_step_i);
                    if (m_lvl >= MAXV) begin m_lvl = MAXV; m_st = S_DEC; end
                end
                S_DEC: begin
                    m_lvl = m_lvl - int'(decay_step_i);
                    if (m_lvl <= sus) begin m_lvl = sus; m_st = S_SUS; end
                end
                S_SUS: m_lvl = sus;
                default: begin
`ifdef ADSR_EXP_RELEASE_EN
                    d = m_lvl >> (int'(release_step_i) % 16);
                    if (d < 1) d = 1;
`else
                    d = int'(release_step_i);
`endif
                    m_lvl = m_lvl - d;
                    if (m_lvl <= 0) begin m_lvl = 0; m_st = S_IDL; end
                end
            endcase
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_env"},   int'(env_o),   m_lvl);
        chk({tag, "_state"}, int'(state_o), m_st);
        chk({tag, "_valid"}, int'(valid_o), int'(m_valid));
        chk({tag, "_idle"},  int'(idle_o),  (m_st == S_IDL) ? 1 : 0);
    endtask

    // One clock: drive, clock in, advance the model, compare away from the edge.
    task automatic step(input string tag, input bit v, input bit g);
        valid_i = v;
        gate_i  = g;
        @(posedge clk_i);
        #1;
        model_tick(v, g);
        check_model(tag);
    endtask

    initial begin
        int atk_exp [4];
        int dec_exp [3];
        int rel_exp [4];
        atk_exp = '{8192, 16384, 24576, 32767};
        dec_exp = '{22767, 12767, 12000};
        rel_exp = '{5000, 3000, 1000, 0};

        rst_i          = 1'b1;
        valid_i        = 1'b0;
        gate_i         = 1'b0;
        attack_step_i  = 16'd8192;
        decay_step_i   = 16'd10000;
        sustain_i      = 16'd12000;
        release_step_i = 16'd2000;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_env", int'(env_o), 0);
        chk("rst_state", int'(state_o), S_IDL);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_idle", int'(idle_o), 1);
        rst_i = 1'b0;
        model_reset();

        // Attack to saturation
        for (int i = 0; i < 4; i++) begin
            step("atk", 1'b1, 1'b1);
            chk("atk_lit", int'(env_o), atk_exp[i]);
            chk("atk_st_lit", int'(state_o), (i == 3) ? S_DEC : S_ATK);
        end

        // Decay into sustain, then live sustain tracking
        for (int i = 0; i < 3; i++) begin
            step("dec", 1'b1, 1'b1);
            chk("dec_lit", int'(env_o), dec_exp[i]);
        end
        chk("sus_st_lit", int'(state_o), S_SUS);
        sustain_i = 16'd5000;
        step("sus", 1'b1, 1'b1);
        chk("sus_lit", int'(env_o), 5000);

        // Release
        for (int i = 0; i < 4; i++) begin
            step("rel", 1'b1, 1'b0);
`ifndef ADSR_EXP_RELEASE_EN
            chk("rel_lit", int'(env_o), rel_exp[i]);
`endif
        end
        while (m_st != S_IDL) step("rel_tail", 1'b1, 1'b0);
        chk("rel_idle_lit", int'(idle_o), 1);

        // Retrigger out of RELEASE at 3000
        attack_step_i = 16'd3000;
        step("rt_a", 1'b1, 1'b1);
        step("rt_r", 1'b1, 1'b0);
        chk("rt_rel_lit", int'(env_o), 3000);
        attack_step_i = 16'd1000;
        step("rt", 1'b1, 1'b1);
        chk("rt_lit", int'(env_o), 4000);
        chk("rt_st_lit", int'(state_o), S_ATK);

        // No ticks: everything holds, no valid pulses
        for (int i = 0; i < 5; i++) begin
            step("gap", 1'b0, 1'b1);
            chk("gap_lit", int'(env_o), 4000);
        end

        // Asynchronous reset between edges, mid-attack
        step("pre_rst", 1'b1, 1'b1);
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        chk("arst_env", int'(env_o), 0);
        chk("arst_state", int'(state_o), S_IDL);
        chk("arst_idle", int'(idle_o), 1);
        rst_i = 1'b0;
        model_reset();

`ifdef ADSR_EXP_RELEASE_EN
        attack_step_i  = 16'd1024;
        release_step_i = 16'd2;
        step("exp_a", 1'b1, 1'b1);
        step("exp_f", 1'b1, 1'b0);
        chk("exp_f_lit", int'(env_o), 1024);
        step("exp", 1'b1, 1'b0);
        chk("exp_lit0", int'(env_o), 768);
        step("exp", 1'b1, 1'b0);
        chk("exp_lit1", int'(env_o), 576);
        step("exp", 1'b1, 1'b0);
        chk("exp_lit2", int'(env_o), 432);
        for (int i = 0; i < 200 && m_st != S_IDL; i++) step("exp_tail", 1'b1, 1'b0);
        chk("exp_idle_lit", int'(idle_o), 1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit v, g;
            if (i % 16 == 0) begin
                attack_step_i  = W'($urandom_range(0, 12000));
                decay_step_i   = W'($urandom_range(0, 12000));
                release_step_i = W'($urandom_range(0, 12000));
                sustain_i      = ($urandom_range(0, 7) == 0) ? W'($urandom_range(32768, 65535))
                                                              : W'($urandom_range(0, 32767));
                if ($urandom_range(0, 9) == 0) attack_step_i  = '0;
                if ($urandom_range(0, 9) == 0) decay_step_i   = '0;
                if ($urandom_range(0, 9) == 0) release_step_i = '0;
            end
            if ($urandom_range(0, 5) == 0) sustain_i = W'($urandom_range(0, 40000));
            v = ($urandom_range(0, 3) != 0);
            g = ($urandom_range(0, 5) == 0) ? ~gate_i : gate_i;
            step("rnd", v, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
